// File: rtl/unidade_logica_nbits.sv
// unidade_logica_nbits: WIDTH-bit bitwise logic unit with eight operations,
// an internal accumulator that can stand in for operand A, zero/parity flags
// and a two-stage valid/ready pipeline with full backpressure.
module unidade_logica_nbits #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             flag_zero,
  output logic             flag_paridade,
  output logic [WIDTH-1:0] acc
);

  // Full 3-bit decode of the logic operation.
  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (sel)
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b010:  r = x ^ y;
      3'b011:  r = ~(x & y);
      3'b100:  r = ~(x | y);
      3'b101:  r = ~(x ^ y);
      3'b110:  r = ~x;
      3'b111:  r = y;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Odd parity of a result word (1 = odd number of ones).
  function automatic logic parity_of(input logic [WIDTH-1:0] x);
    return ^x;
  endfunction

  // Stage 1 registers
  logic             v1_r;
  logic [2:0]       op_r;
  logic             acc_sel_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  // Handshake / advance controls
  logic             accept_s;
  logic             advance_s;
  logic             drain_s;
  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] result_s;

  // S1 may take a new transaction unless both stages are full and the
  // output is stalled; this is the only combinational output.
  assign in_ready  = !v1_r || !out_valid || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign advance_s = v1_r && (!out_valid || out_ready);
  assign drain_s   = out_valid && out_ready;

  // Operand selection and result computation from the S1 registers.
  always_comb begin
    op_a_s   = a_r;
    result_s = {WIDTH{1'b0}};
    if (acc_sel_r) begin
      op_a_s = acc;
    end else begin
      op_a_s = a_r;
    end
    result_s = logic_op(op_r, op_a_s, b_r);
  end

  // Stage 1: capture the operands on an input handshake, empty when they move on.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r      <= 1'b0;
      op_r      <= 3'b000;
      acc_sel_r <= 1'b0;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      v1_r      <= 1'b1;
      op_r      <= op;
      acc_sel_r <= acc_sel;
      a_r       <= a;
      b_r       <= b;
    end else if (advance_s) begin
      v1_r      <= 1'b0;
    end
  end

  // Stage 2: register result, flags and accumulator when S1 advances; hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      s             <= {WIDTH{1'b0}};
      flag_zero     <= 1'b1;
      flag_paridade <= 1'b0;
      acc           <= {WIDTH{1'b0}};
    end else if (advance_s) begin
      out_valid     <= 1'b1;
      s             <= result_s;
      flag_zero     <= (result_s == {WIDTH{1'b0}});
      flag_paridade <= parity_of(result_s);
      acc           <= result_s;
    end else if (drain_s) begin
      out_valid     <= 1'b0;
    end
  end

endmodule
